mc_controller: RTL
==================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameters: none; all widths and encodings are fixed by this document.
REQ-002 clk  in  1  single clock, all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 op  in  6  instruction opcode field, taken from the instruction register.
REQ-005 funct  in  6  instruction funct field, taken from the instruction register.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  memory handshake; 1 = current access completes this cycle.
REQ-008 iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 memwrite  out  1  memory write strobe.
REQ-010 irwrite  out  1  instruction register load enable.
REQ-011 regdst  out  1  register write address: 0 = rt, 1 = rd.
REQ-012 memtoreg  out  1  register write data: 0 = ALUOut, 1 = memory data register.
REQ-013 regwrite  out  1  register file write enable.
REQ-014 alusrca  out  1  ALU operand A: 0 = PC, 1 = register A.
REQ-015 alusrcb  out  2  ALU operand B: 00 = register B, 01 = constant 4, 10 = signimm, 11 = signimm<<2.
REQ-016 pcsrc  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-017 pcen  out  1  PC load enable.
REQ-018 alucontrol  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-019 illegal  out  1  one-cycle pulse in DECODE when op is unsupported.
REQ-020 state  out  4  current FSM state code (debug/verification).

Function
REQ-021 Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-022 State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11; codes 12-15 are unreachable.
REQ-023 FETCH: iord=0, alusrca=0, alusrcb=01, pcsrc=00, alucontrol=add; irwrite and pcen equal mem_ready; go to DECODE when mem_ready=1, otherwise stay in FETCH.
REQ-024 DECODE: alusrca=0, alusrcb=11, alucontrol=add (branch target into ALUOut); next state by op: lw/sw -> MEMADR, R-type -> RTYPEEX, beq -> BEQEX, addi -> ADDIEX, j -> JEX; any other op -> FETCH with illegal=1.
REQ-025 MEMADR: alusrca=1, alusrcb=10, alucontrol=add; go to MEMRD for lw, MEMWR for sw.
REQ-026 MEMRD: iord=1; go to MEMWB when mem_ready=1, otherwise stay.
REQ-027 MEMWB: regdst=0, memtoreg=1, regwrite=1; go to FETCH.
REQ-028 MEMWR: iord=1, memwrite=1; memwrite stays asserted until the cycle in which mem_ready=1; then go to FETCH.
REQ-029 RTYPEEX: alusrca=1, alusrcb=00, alucontrol decoded from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, any other funct add; go to RTYPEWB.
REQ-030 RTYPEWB: regdst=1, memtoreg=0, regwrite=1; go to FETCH.
REQ-031 BEQEX: alusrca=1, alusrcb=00, alucontrol=sub, pcsrc=01, pcen=zero (combinational); go to FETCH.
REQ-032 ADDIEX: alusrca=1, alusrcb=10, alucontrol=add; go to ADDIWB.
REQ-033 ADDIWB: regdst=0, memtoreg=0, regwrite=1; go to FETCH.
REQ-034 JEX: pcsrc=10, pcen=1; go to FETCH.
REQ-035 Every output not listed for a state is 0 in that state; alucontrol defaults to 010.
REQ-036 Only pcen, irwrite (FETCH) and memwrite exit timing depend combinationally on inputs; all other outputs are decoded from state.
REQ-037 If state holds an unreachable code, next state is FETCH and all write enables are 0.
REQ-038 Latency with mem_ready tied to 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3; each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.

Reset
REQ-039 While rst=1 at a clock edge, the next state is FETCH; a reset mid-instruction aborts it with no further register or memory write.
REQ-040 While rst=1, memwrite, irwrite, regwrite, pcen and illegal are forced to 0, regardless of state.
REQ-041 In the first cycle after rst deasserts, state=0 (FETCH).

Verification
REQ-042 Reset, then R-type add (op 000000, funct 100000), mem_ready=1 -> state sequence 0,1,6,7,0; regwrite=1 and regdst=1 only in state 7.
REQ-043 lw with mem_ready=0 for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; iord=1 in each MEMRD cycle; regwrite=1 with memtoreg=1 in state 4.
REQ-044 sw with mem_ready low for 3 cycles in MEMWR -> memwrite=1 for exactly 4 cycles, then state 0.
REQ-045 beq with zero=1, then with zero=0 -> pcen=1 with pcsrc=01 in state 8 for the first, pcen=0 for the second.
REQ-046 op 111111 -> illegal=1 for one cycle in state 1, then state 0, no write enable asserted.
REQ-047 rst=1 asserted during state 4 (MEMWB) -> regwrite=0 in that cycle, state=0 after the reset edge.

Source files
------------

// File: rtl/mc_controller.sv
// Multi-cycle MIPS-subset control FSM: sequences fetch/decode/execute/writeback
// and decodes datapath control signals from the current state.
module mc_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state
);

    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALU_W   = 3;
    localparam int unsigned STATE_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;

    // State register; reset returns to FETCH and aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; write enables are suppressed while in reset.
    always_comb begin
        state_d    = state_q;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        pcen       = 1'b0;
        alucontrol = ALU_ADD;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcen    = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                case (funct)
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    FN_ADD:  alucontrol = ALU_ADD;
                    default: alucontrol = ALU_ADD;
                endcase
                state_d = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = zero;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JEX: begin
                pcsrc   = 2'b10;
                pcen    = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (rst) begin
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            pcen     = 1'b0;
            illegal  = 1'b0;
        end
    end

    // Debug view of the current state code.
    assign state = STATE_W'(state_q);

endmodule
